hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Drives the enable of the PC register and the F/D flow register, and the clear of the D/E flow register.
- Compares D-stage source-register Tuse against E/M-stage destination Tnew.
- Tracks the multi-cycle mult/div unit with an internal busy counter, so HI/LO or md instructions in D stall until the unit is idle.

Parameters:
- MULT_LAT, 5, cycles mult occupies the md unit after leaving E
- DIV_LAT, 10, cycles div occupies the md unit after leaving E
- CNT_W, 4, busy counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- rs_D  input  5  rs field of instruction in D
- rt_D  input  5  rt field of instruction in D
- tuse_rs_D  input  2  cycles until rs is needed (3 = unused)
- tuse_rt_D  input  2  cycles until rt is needed (3 = unused)
- md_use_D  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- wreg_E  input  5  destination register of E instruction (0 = none)
- tnew_E  input  2  cycles until E result is forwardable
- wreg_M  input  5  destination register of M instruction (0 = none)
- tnew_M  input  2  cycles until M result is forwardable
- mult_start_E  input  1  E holds mult/multu this cycle
- div_start_E  input  1  E holds div/divu this cycle
- en_pc  output  1  PC register enable
- en_d  output  1  F/D flow register enable
- clr_e  output  1  D/E flow register synchronous clear (bubble insert)
- md_busy  output  1  md unit busy, valid this cycle

Behaviour:
- Reset (async, reset=1): busy counter cnt=0. Outputs then follow the combinational rules below; with idle inputs en_pc=1, en_d=1, clr_e=0, md_busy=0.
- Data hazard, per source src in {rs, rt}:
  - stall_src = (src_D != 0) && ((src_D == wreg_E && tuse_src_D < tnew_E) || (src_D == wreg_M && tuse_src_D < tnew_M)).
  - Register 0 never stalls.
  - Equal Tuse/Tnew does not stall; the forwarding path handles it.
- md busy: md_busy = mult_start_E | div_start_E | (cnt != 0).
- md stall: stall_md = md_use_D & md_busy.
- stall = stall_rs | stall_rt | stall_md.
- Outputs are combinational, same cycle, no added latency:
  - en_pc = ~stall
  - en_d = ~stall
  - clr_e = stall
- Counter update at posedge clk (priority order):
  - div_start_E=1: cnt <= DIV_LAT.
  - else mult_start_E=1: cnt <= MULT_LAT.
  - else cnt != 0: cnt <= cnt-1.
  - else hold 0.
- Both starts asserted together is illegal; div wins.
- A start while cnt != 0 reloads cnt; no accumulation.
- cnt never wraps below 0.
- Timing: a mult entering E at cycle t gives md_busy=1 for cycles t..t+MULT_LAT. A dependent md instruction sitting in D is released at cycle t+MULT_LAT+1.
- Reset mid-count: cnt clears immediately; md_busy drops in the same cycle unless a start input is high.
- Stall is a pure function of the current cycle: no latched stall state, no multi-cycle hold beyond what cnt provides.

Optional Feature:
- Macro STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0].
  - Increments at posedge when stall=1, saturating at 32'hFFFFFFFF.
  - Cleared asynchronously by reset.
  - Used for CPI profiling.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Load-use hazard: rs_D=5, tuse_rs_D=0, wreg_E=5, tnew_E=2 -> en_pc=0, en_d=0, clr_e=1 that cycle. Next cycle with wreg_M=5, tnew_M=1 -> still stalled. Following cycle tnew_M=0 -> en_pc=1.
2. Register zero: rs_D=0, wreg_E=0, tnew_E=2, tuse_rs_D=0 -> no stall. Also rt_D=7, tuse_rt_D=1, wreg_E=7, tnew_E=1 -> no stall (equal, forwarded).
3. Mult occupancy: mult_start_E=1 at cycle 0, then md_use_D=1 held -> stall=1 on cycles 0..5, released on cycle 6. md_busy=0 from cycle 6 with no new start.
4. Div then mult reload: div_start_E at cycle 0, mult_start_E at cycle 3 -> cnt=5 after cycle 3 edge. md_busy falls at cycle 9, not 11.
5. Async reset mid-div: div_start_E at cycle 0, reset pulse between edges at cycle 4 -> md_busy=0 immediately; en_pc=1 with md_use_D=1 and no data hazard.
6. STALL_CNT_EN defined: 3-cycle load-use stall plus 6-cycle md stall -> stall_cnt=9. Reset -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: Tuse/Tnew data-hazard
// detection plus a busy counter covering the multi-cycle mult/div unit.
// Optional macro STALL_CNT_EN adds a saturating stall-cycle counter output.
module hazard_stall_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4   // must be wide enough to hold max(MULT_LAT, DIV_LAT)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic        md_use_D,
  input  logic [4:0]  wreg_E,
  input  logic [1:0]  tnew_E,
  input  logic [4:0]  wreg_M,
  input  logic [1:0]  tnew_M,
  input  logic        mult_start_E,
  input  logic        div_start_E,
  output logic        en_pc,
  output logic        en_d,
  output logic        clr_e,
  output logic        md_busy
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_rs, stall_rt, stall_md, stall;

  // Equal Tuse/Tnew is covered by forwarding, so only a strictly later result stalls.
  always_comb begin
    stall_rs = (rs_D != 5'd0) &&
               ((rs_D == wreg_E && tuse_rs_D < tnew_E) ||
                (rs_D == wreg_M && tuse_rs_D < tnew_M));
    stall_rt = (rt_D != 5'd0) &&
               ((rt_D == wreg_E && tuse_rt_D < tnew_E) ||
                (rt_D == wreg_M && tuse_rt_D < tnew_M));
  end

  assign md_busy  = mult_start_E | div_start_E | (cnt_q != '0);
  assign stall_md = md_use_D & md_busy;
  assign stall    = stall_rs | stall_rt | stall_md;

  assign en_pc = ~stall;
  assign en_d  = ~stall;
  assign clr_e = stall;

  // A new start reloads rather than accumulates; div wins if both starts collide.
  always_comb begin
    cnt_d = cnt_q;
    if (div_start_E) begin
      cnt_d = CNT_W'(DIV_LAT);
    end else if (mult_start_E) begin
      cnt_d = CNT_W'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_hazard_stall_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, wreg_E, wreg_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        md_use_D, mult_start_E, div_start_E;
  logic        en_pc, en_d, clr_e, md_busy;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_stall_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .md_use_D(md_use_D), .wreg_E(wreg_E), .tnew_E(tnew_E),
    .wreg_M(wreg_M), .tnew_M(tnew_M),
    .mult_start_E(mult_start_E), .div_start_E(div_start_E),
    .en_pc(en_pc), .en_d(en_d), .clr_e(clr_e), .md_busy(md_busy)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;
  bit chk_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the md unit is busy through an absolute cycle number recorded at each start.
  int          cyc        = 0;
  int          busy_until = -1;
  longint      sc_model   = 0;

  function automatic bit src_stall(input logic [4:0] src, input logic [1:0] tuse);
    if (src == 5'd0) return 1'b0;
    if (src == wreg_E && int'(tnew_E) > int'(tuse)) return 1'b1;
    if (src == wreg_M && int'(tnew_M) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_busy();
    return mult_start_E || div_start_E || (cyc <= busy_until);
  endfunction

  function automatic bit model_stall();
    return src_stall(rs_D, tuse_rs_D) || src_stall(rt_D, tuse_rt_D) ||
           (md_use_D && model_busy());
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_until = -1;
      sc_model   = 0;
    end else begin
      if (model_stall() && sc_model < 64'hFFFF_FFFF) sc_model++;
      if (div_start_E)       busy_until = cyc + DIV_LAT;
      else if (mult_start_E) busy_until = cyc + MULT_LAT;
    end
    if (!reset) cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_en_pc",   {31'd0, en_pc},   {31'd0, ~model_stall()});
      check("cmp_en_d",    {31'd0, en_d},    {31'd0, ~model_stall()});
      check("cmp_clr_e",   {31'd0, clr_e},   {31'd0, model_stall()});
      check("cmp_md_busy", {31'd0, md_busy}, {31'd0, model_busy()});
`ifdef STALL_CNT_EN
      check("cmp_stall_cnt", stall_cnt, sc_model[31:0]);
`endif
    end
  end

  task automatic set_idle();
    rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    md_use_D = 1'b0; wreg_E = 5'd0; tnew_E = 2'd0; wreg_M = 5'd0; tnew_M = 2'd0;
    mult_start_E = 1'b0; div_start_E = 1'b0;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_en_pc", {31'd0, en_pc}, 32'd1);
    check("reset_en_d", {31'd0, en_d}, 32'd1);
    check("reset_clr_e", {31'd0, clr_e}, 32'd0);
    check("reset_md_busy", {31'd0, md_busy}, 32'd0);
`ifdef STALL_CNT_EN
    check("reset_stall_cnt", stall_cnt, 32'd0);
`endif
    chk_en = 1'b1;

    // Load-use: E result two cycles away, then M one away, then ready.
    next_cycle();
    rs_D = 5'd5; tuse_rs_D = 2'd0; wreg_E = 5'd5; tnew_E = 2'd2;
    @(negedge clk);
    check("lu_e_en_pc", {31'd0, en_pc}, 32'd0);
    check("lu_e_clr_e", {31'd0, clr_e}, 32'd1);
    next_cycle();
    wreg_E = 5'd0; tnew_E = 2'd0; wreg_M = 5'd5; tnew_M = 2'd1;
    @(negedge clk);
    check("lu_m_en_d", {31'd0, en_d}, 32'd0);
    next_cycle();
    tnew_M = 2'd0;
    @(negedge clk);
    check("lu_rel_en_pc", {31'd0, en_pc}, 32'd1);

    // Register zero never stalls; equal Tuse/Tnew is forwarded.
    next_cycle();
    set_idle();
    rs_D = 5'd0; tuse_rs_D = 2'd0; wreg_E = 5'd0; tnew_E = 2'd2;
    @(negedge clk);
    check("r0_en_pc", {31'd0, en_pc}, 32'd1);
    next_cycle();
    set_idle();
    rt_D = 5'd7; tuse_rt_D = 2'd1; wreg_E = 5'd7; tnew_E = 2'd1;
    @(negedge clk);
    check("eq_clr_e", {31'd0, clr_e}, 32'd0);

    // Mult occupancy: stall on cycles 0..5, release on cycle 6.
    next_cycle();
    set_idle();
    md_use_D = 1'b1; mult_start_E = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin
        next_cycle();
        mult_start_E = 1'b0;
      end
      @(negedge clk);
      check($sformatf("mult_c%0d_en_pc", c), {31'd0, en_pc}, (c <= 5) ? 32'd0 : 32'd1);
      check($sformatf("mult_c%0d_busy", c), {31'd0, md_busy}, (c <= 5) ? 32'd1 : 32'd0);
    end

    // Div at cycle 0, mult reload at cycle 3: busy falls at cycle 9.
    next_cycle();
    set_idle();
    div_start_E = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) begin
        next_cycle();
        div_start_E  = 1'b0;
        mult_start_E = (c == 3);
      end
      @(negedge clk);
      check($sformatf("reload_c%0d_busy", c), {31'd0, md_busy}, (c <= 8) ? 32'd1 : 32'd0);
    end

    // Async reset between edges mid-div.
    next_cycle();
    set_idle();
    div_start_E = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      div_start_E = 1'b0;
    end
    md_use_D = 1'b1;
    #1;
    check("mid_div_busy", {31'd0, md_busy}, 32'd1);
    pulse_reset();
    #1;
    check("rst_div_busy", {31'd0, md_busy}, 32'd0);
    check("rst_div_en_pc", {31'd0, en_pc}, 32'd1);

`ifdef STALL_CNT_EN
    // Six md stall cycles then three load-use stall cycles.
    next_cycle();
    set_idle();
    pulse_reset();
    md_use_D = 1'b1; mult_start_E = 1'b1;
    next_cycle();
    mult_start_E = 1'b0;
    repeat (5) next_cycle();
    set_idle();
    rs_D = 5'd9; tuse_rs_D = 2'd0; wreg_E = 5'd9; tnew_E = 2'd2;
    repeat (3) next_cycle();
    set_idle();
    @(negedge clk);
    check("scnt_nine", stall_cnt, 32'd9);
    next_cycle();
    pulse_reset();
    #1;
    check("scnt_reset", stall_cnt, 32'd0);
`endif

    // Randomized traffic with small register indices to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      int r;
      next_cycle();
      rs_D = 5'($urandom_range(0, 3));
      rt_D = 5'($urandom_range(0, 3));
      tuse_rs_D = 2'($urandom_range(0, 3));
      tuse_rt_D = 2'($urandom_range(0, 3));
      wreg_E = 5'($urandom_range(0, 3));
      wreg_M = 5'($urandom_range(0, 3));
      tnew_E = 2'($urandom_range(0, 3));
      tnew_M = 2'($urandom_range(0, 3));
      md_use_D = ($urandom_range(0, 2) == 0);
      r = int'($urandom_range(0, 19));
      mult_start_E = (r == 0 || r == 2);
      div_start_E  = (r == 1 || r == 2);
      if ($urandom_range(0, 59) == 0) pulse_reset();
    end

    next_cycle();
    set_idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
